// File: rtl/minitb_ahb_slave_mem.sv
// AHB-Lite responder with a word-addressed memory, fixed wait states
// and a two-cycle ERROR response for out-of-range addresses.
module minitb_ahb_slave_mem #(
    parameter int addrWidth   = 8,
    parameter int dataWidth   = 32,
    parameter int MEM_DEPTH   = 2**addrWidth,
    parameter int WAIT_STATES = 0
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic                 hsel,
    input  logic [1:0]           htrans,
    input  logic [addrWidth-1:0] haddr,
    input  logic                 hwrite,
    input  logic [dataWidth-1:0] hwdata,
    output logic                 hready,
    output logic [1:0]           hresp,
    output logic [dataWidth-1:0] hrdata
);

    localparam int ARRAY_WORDS = 2**addrWidth;
    localparam logic [addrWidth:0] DEPTH_W = (addrWidth+1)'(MEM_DEPTH);
    localparam logic [3:0] WS_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam bit NO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2
    } state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [addrWidth-1:0] addr_dp;
    logic write_dp;
    logic accept;
    logic addr_err;
    logic commit;
    logic rd_enter;
    logic [addrWidth-1:0] rd_addr;
    logic [dataWidth-1:0] mem [ARRAY_WORDS];

    assign addr_err = ({1'b0, haddr} >= DEPTH_W);
    assign commit   = (state == S_DATA) && write_dp;

    // State register and wait counter.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, bus outputs and address-phase acceptance.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hready    = 1'b1;
        hresp     = 2'b00;
        unique case (state)
            S_IDLE: state_nxt = S_IDLE;
            S_WAIT: begin
                hready = 1'b0;
                if (cnt == 4'd0) state_nxt = S_DATA;
                else cnt_nxt = cnt - 4'd1;
            end
            S_DATA: state_nxt = S_IDLE;
            S_ERR1: begin
                hready    = 1'b0;
                hresp     = 2'b01;
                state_nxt = S_ERR2;
            end
            S_ERR2: begin
                hresp     = 2'b01;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        accept = hready && hsel && htrans[1];
        if (accept) begin
            if (addr_err) begin
                state_nxt = S_ERR1;
            end else if (!NO_WAIT) begin
                state_nxt = S_WAIT;
                cnt_nxt   = WS_INIT;
            end else begin
                state_nxt = S_DATA;
            end
        end
    end

    // Pick the address of a read that enters its final data cycle now.
    always_comb begin
        rd_enter = 1'b0;
        rd_addr  = addr_dp;
        if (NO_WAIT && accept && !addr_err && !hwrite) begin
            rd_enter = 1'b1;
            rd_addr  = haddr;
        end else if (state == S_WAIT && cnt == 4'd0 && !write_dp) begin
            rd_enter = 1'b1;
        end
    end

    // Data-phase control captured when an address phase is accepted.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_dp  <= '0;
            write_dp <= 1'b0;
        end else if (accept) begin
            addr_dp  <= haddr;
            write_dp <= hwrite;
        end
    end

    // Memory array; writes commit on the last data-phase cycle.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < ARRAY_WORDS; i++) mem[i] <= '0;
        end else if (commit) begin
            mem[addr_dp] <= hwdata;
        end
    end

    // Read data register, forwarding a same-edge write to the same word.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hrdata <= '0;
        end else if (rd_enter) begin
            if (commit && addr_dp == rd_addr) hrdata <= hwdata;
            else hrdata <= mem[rd_addr];
        end else if (state_nxt == S_ERR1) begin
            hrdata <= '0;
        end
    end

endmodule

// File: tb/tb_minitb_ahb_slave_mem.sv
// Directed bench: instance A (no waits, 128 words) and instance B
// (3 wait states, 256 words) share the bus but have separate selects.
module tb_minitb_ahb_slave_mem;

    logic        clk;
    logic        rst_n;
    logic        hsel_a, hsel_b;
    logic [1:0]  htrans;
    logic [7:0]  haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready_a, hready_b;
    logic [1:0]  hresp_a, hresp_b;
    logic [31:0] hrdata_a, hrdata_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    int          lows;
    logic [1:0]  rlow, rend;

    minitb_ahb_slave_mem #(
        .addrWidth(8), .dataWidth(32), .MEM_DEPTH(128), .WAIT_STATES(0)
    ) u_a (
        .hclk(clk), .hresetn(rst_n), .hsel(hsel_a), .htrans(htrans),
        .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata),
        .hready(hready_a), .hresp(hresp_a), .hrdata(hrdata_a)
    );

    minitb_ahb_slave_mem #(
        .addrWidth(8), .dataWidth(32), .MEM_DEPTH(256), .WAIT_STATES(3)
    ) u_b (
        .hclk(clk), .hresetn(rst_n), .hsel(hsel_b), .htrans(htrans),
        .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata),
        .hready(hready_b), .hresp(hresp_b), .hrdata(hrdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One non-pipelined transfer on slave A (sb=0) or B (sb=1).
    task automatic xfer(input bit sb, input bit wr, input logic [7:0] a,
                        input logic [31:0] wd, output logic [31:0] rdv,
                        output int nlow, output logic [1:0] resp_low,
                        output logic [1:0] resp_end);
        bit done;
        @(negedge clk);
        hsel_a = !sb;
        hsel_b = sb;
        htrans = 2'b10;
        haddr  = a;
        hwrite = wr;
        @(negedge clk);
        hsel_a = 1'b0;
        hsel_b = 1'b0;
        htrans = 2'b00;
        hwdata = wd;
        nlow = 0;
        resp_low = 2'b00;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ((sb ? hready_b : hready_a) === 1'b1) begin
                done = 1'b1;
                break;
            end
            if (nlow == 0) resp_low = sb ? hresp_b : hresp_a;
            nlow++;
            @(negedge clk);
        end
        rdv = sb ? hrdata_b : hrdata_a;
        resp_end = sb ? hresp_b : hresp_a;
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL xfer_timeout observed %0d expected hready", nlow);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        hsel_a = 1'b0;
        hsel_b = 1'b0;
        htrans = 2'b00;
        haddr  = '0;
        hwrite = 1'b0;
        hwdata = '0;
        @(negedge clk);
        chk("rst_hready", 32'(hready_a), 32'd1);
        chk("rst_hresp", 32'(hresp_a), 32'd0);
        chk("rst_hrdata", hrdata_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // idle bus for 5 clocks
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_rdy_a", 32'(hready_a), 32'd1);
            chk("idle_resp_a", 32'(hresp_a), 32'd0);
            chk("idle_data_a", hrdata_a, 32'd0);
            chk("idle_rdy_b", 32'(hready_b), 32'd1);
        end

        // zero-wait write then read
        xfer(0, 1, 8'h10, 32'hDEADBEEF, rd, lows, rlow, rend);
        chk("w10_lows", 32'(lows), 32'd0);
        chk("w10_resp", 32'(rend), 32'd0);
        xfer(0, 0, 8'h10, 32'h0, rd, lows, rlow, rend);
        chk("r10_lows", 32'(lows), 32'd0);
        chk("r10_data", rd, 32'hDEADBEEF);

        // back-to-back write then read of the same word
        @(negedge clk);
        hsel_a = 1'b1;
        htrans = 2'b10;
        haddr  = 8'h20;
        hwrite = 1'b1;
        @(negedge clk);
        chk("b2b_rdy_w", 32'(hready_a), 32'd1);
        hwdata = 32'h11111111;
        hwrite = 1'b0;
        @(negedge clk);
        chk("b2b_rdy_r", 32'(hready_a), 32'd1);
        chk("b2b_fwd", hrdata_a, 32'h11111111);
        hsel_a = 1'b0;
        htrans = 2'b00;
        xfer(0, 0, 8'h20, 32'h0, rd, lows, rlow, rend);
        chk("r20_mem", rd, 32'h11111111);

        // boundary: last valid word and first invalid word
        xfer(0, 1, 8'h7F, 32'h0000005A, rd, lows, rlow, rend);
        chk("w7f_lows", 32'(lows), 32'd0);
        chk("w7f_resp", 32'(rend), 32'd0);
        xfer(0, 1, 8'h90, 32'h00001234, rd, lows, rlow, rend);
        chk("w90_lows", 32'(lows), 32'd1);
        chk("w90_resp1", 32'(rlow), 32'd1);
        chk("w90_resp2", 32'(rend), 32'd1);
        xfer(0, 0, 8'h7F, 32'h0, rd, lows, rlow, rend);
        chk("r7f_data", rd, 32'h0000005A);
        xfer(0, 0, 8'h90, 32'h0, rd, lows, rlow, rend);
        chk("r90_lows", 32'(lows), 32'd1);
        chk("r90_resp1", 32'(rlow), 32'd1);
        chk("r90_resp2", 32'(rend), 32'd1);
        chk("r90_data", rd, 32'h0);
        xfer(0, 0, 8'h10, 32'h0, rd, lows, rlow, rend);
        chk("r10_kept", rd, 32'hDEADBEEF);
        chk("r10_resp", 32'(rend), 32'd0);

        // three wait states
        xfer(1, 1, 8'h05, 32'hA5A5A5A5, rd, lows, rlow, rend);
        chk("w05_lows", 32'(lows), 32'd3);
        chk("w05_resp", 32'(rend), 32'd0);
        xfer(1, 0, 8'h05, 32'h0, rd, lows, rlow, rend);
        chk("r05_lows", 32'(lows), 32'd3);
        chk("r05_data", rd, 32'hA5A5A5A5);

        // reset during the wait state of a write
        @(negedge clk);
        hsel_b = 1'b1;
        htrans = 2'b10;
        haddr  = 8'h30;
        hwrite = 1'b1;
        @(negedge clk);
        chk("w30_wait", 32'(hready_b), 32'd0);
        hsel_b = 1'b0;
        htrans = 2'b00;
        hwdata = 32'hCAFEF00D;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_rdy", 32'(hready_b), 32'd1);
        chk("rst_async_resp", 32'(hresp_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1, 0, 8'h30, 32'h0, rd, lows, rlow, rend);
        chk("r30_lows", 32'(lows), 32'd3);
        chk("r30_data", rd, 32'h0);
        xfer(1, 0, 8'h05, 32'h0, rd, lows, rlow, rend);
        chk("r05_cleared", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/minitb_ahb_slave_mem.md
Name: minitb_ahb_slave_mem

Overview:
Synthesizable AHB-Lite responder that is the target for the miniTB AHB master driver in unit tests. It contains a word-addressed memory and follows the standard address-phase/data-phase pipeline. It can insert a fixed number of wait states per transfer. Out-of-range addresses get a two-cycle ERROR response.

Parameters:
addrWidth, 8, haddr width; haddr is a word index, with no byte lanes.
dataWidth, 32, hwdata/hrdata width.
MEM_DEPTH, 2**addrWidth, number of words; addresses >= MEM_DEPTH are errors.
WAIT_STATES, 0, cycles of hready low inserted in every OKAY data phase (0..15).

Ports:
hclk  input  1  bus clock; all state changes on posedge.
hresetn  input  1  asynchronous, active-low reset.
hsel  input  1  slave select, qualifies the address phase.
htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
haddr  input  addrWidth  transfer word address.
hwrite  input  1  1=write, 0=read.
hwdata  input  dataWidth  write data, valid in the data phase.
hready  output  1  transfer done / bus ready; this block is the only slave, so it also acts as the bus hready.
hresp  output  2  00=OKAY, 01=ERROR.
hrdata  output  dataWidth  read data, valid when hready=1 in a read data phase.

Behaviour:
- Reset (async assert, sync release): hready=1, hresp=00, hrdata=0, FSM=IDLE, memory cleared to 0, no pending data phase. A reset during a data phase abandons it and does not commit the write.
- Address accept: on posedge where hready=1 && hsel=1 && htrans[1]=1. SEQ is treated as NONSEQ. BUSY and IDLE are ignored and give a zero-wait OKAY.
- On accept, the block registers addr_dp, write_dp, and err_dp (err_dp = haddr >= MEM_DEPTH).
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: hready=1, hresp=00. On accept: err_dp -> ERR1; else WAIT_STATES>0 -> WAIT (counter=WAIT_STATES-1); else -> DATA.
  - WAIT: hready=0, hresp=00. Counter decrements; at 0 -> DATA.
  - DATA: hready=1, hresp=00; this is the last data-phase cycle. At posedge: if write_dp, mem[addr_dp]<=hwdata. A new transfer may be accepted on the same edge (back-to-back); next state follows the IDLE rules, else -> IDLE.
  - ERR1: hready=0, hresp=01 -> ERR2.
  - ERR2: hready=1, hresp=01. No memory write; hrdata=0. Accept allowed on this edge, next state per IDLE rules.
- Read latency with WAIT_STATES=0: hrdata is valid in the cycle right after the address phase, so a read's data phase completes one clock after it is accepted.
- hrdata is registered from mem[addr] when the read enters DATA. It holds its value outside read data phases.
- Read-after-write forwarding: if a read enters DATA on the same edge that a write to the same address commits, hrdata = hwdata of that write (the new value, never the stale memory value).
- A write followed by a read to a different address needs no stall.
- While hready=0, haddr/htrans/hwrite are ignored; the master must hold them.
- Simultaneous accept and error completion (ERR2 edge): the new transfer is accepted normally.
- Address wrap: none. Any haddr >= MEM_DEPTH errors; MEM_DEPTH-1 is valid.
- hresp=01 is never driven with hready=1 unless the previous cycle was ERR1.

Test Plan:
1. Reset, then idle for 5 clocks -> hready=1, hresp=00, hrdata=0 throughout.
2. WAIT_STATES=0: write 0x10<-0xDEADBEEF, then read 0x10 -> hready never low; read returns 0xDEADBEEF one clock after the read address phase.
3. Back-to-back write 0x20<-0x11111111 then read 0x20 on consecutive cycles -> forwarding returns 0x11111111; mem[0x20]=0x11111111.
4. WAIT_STATES=3: read 0x05 after write 0x05<-0xA5A5A5A5 -> exactly 3 hready-low cycles per transfer; read returns 0xA5A5A5A5.
5. MEM_DEPTH=128: write 0x90<-0x1234, then read 0x90 -> each transfer gets hready=0/hresp=01 then hready=1/hresp=01; memory unchanged; read hrdata=0.
6. Assert hresetn during the WAIT state of a write to 0x30 (0xCAFEF00D) -> hready=1 immediately; a later read of 0x30 returns 0x00000000.
